// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// The core writes bytes into TXDATA. A baud-rate state machine shifts them
// out LSB first on tx_out as start bit, 8 data bits, stop bit. Reads are
// combinational so the core's memory stage sees data in the access cycle.
//
// Ports:
//   clk_in    - single clock, rising edge
//   reset_in  - asynchronous, active-high reset
//   ce_in     - block select from the bus decoder
//   we_in     - write strobe, qualified by ce_in
//   addr_in   - byte address, bits [3:2] select the register
//   wdata_in  - write data
//   rdata_out - combinational read data, 0 when ce_in is low
//   tx_out    - registered serial line, idles high
//
// Register map (addr_in[3:2]):
//   0 TXDATA   W: push wdata_in[7:0]; R: 0
//   1 STATUS   R: {count[8:4], overflow, busy, empty, full}; W: bit3=1 clears overflow
//   2 BAUD_DIV R/W [15:0] clocks per bit; writing 0 stores 1
//   3 reserved
module uart_tx_mmio #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        ce_in,
    input  logic        we_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] rdata_out,
    output logic        tx_out
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
    typedef enum logic [1:0] {R_TXDATA, R_STATUS, R_BAUD, R_RSVD} reg_e;

    state_e          state_q, state_d;
    logic            tx_q, tx_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     bit_timer_q, bit_timer_d;
    logic [15:0]     active_div_q, active_div_d;
    logic [15:0]     baud_div_q, baud_div_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    reg_e            reg_sel;
    logic            fifo_full, fifo_empty;
    logic            wr_txdata, push, pop;
    logic [7:0]      fifo_head;

    // Only addr_in[3:2] and wdata_in[15:0] carry meaning.
    logic            unused_bits;
    assign unused_bits = ^{addr_in[31:4], addr_in[1:0], wdata_in[31:16]};

    assign reg_sel    = reg_e'(addr_in[3:2]);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    // A write to a full FIFO is dropped even if the FSM pops at the same edge.
    assign wr_txdata  = ce_in & we_in & (reg_sel == R_TXDATA);
    assign push       = wr_txdata & ~fifo_full;
    assign tx_out     = tx_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        tx_d         = tx_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        bit_timer_d  = bit_timer_q;
        active_div_d = active_div_q;
        baud_div_d   = baud_div_q;
        overflow_d   = overflow_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    state_d      = S_START;
                    shift_d      = fifo_head;
                    active_div_d = baud_div_q;
                    tx_d         = 1'b0;
                    bit_timer_d  = baud_div_q - 16'd1;
                end
            end
            S_START: begin
                if (bit_timer_q == '0) begin
                    state_d     = S_DATA;
                    tx_d        = shift_q[0];
                    bit_idx_d   = '0;
                    bit_timer_d = active_div_q - 16'd1;
                end else begin
                    bit_timer_d = bit_timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_timer_q == '0) begin
                    bit_timer_d = active_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next bit is the one that becomes shift[0] after this shift.
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_timer_d = bit_timer_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_timer_q == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop          = 1'b1;
                        state_d      = S_START;
                        shift_d      = fifo_head;
                        active_div_d = baud_div_q;
                        tx_d         = 1'b0;
                        bit_timer_d  = baud_div_q - 16'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_timer_d = bit_timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_txdata && fifo_full) begin
            overflow_d = 1'b1;
        end else if (ce_in && we_in && reg_sel == R_STATUS && wdata_in[3]) begin
            overflow_d = 1'b0;
        end

        if (ce_in && we_in && reg_sel == R_BAUD) begin
            baud_div_d = (wdata_in[15:0] == '0) ? 16'd1 : wdata_in[15:0];
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        rdata_out = '0;
        if (ce_in) begin
            case (reg_sel)
                R_STATUS: begin
                    rdata_out[4 +: CW] = count_q;
                    rdata_out[3]       = overflow_q;
                    rdata_out[2]       = (state_q != S_IDLE);
                    rdata_out[1]       = fifo_empty;
                    rdata_out[0]       = fifo_full;
                end
                R_BAUD:  rdata_out[15:0] = baud_div_q;
                default: rdata_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_in) begin
            state_q      <= S_IDLE;
            tx_q         <= 1'b1;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            bit_timer_q  <= '0;
            active_div_q <= '0;
            baud_div_q   <= DEFAULT_DIV;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            bit_timer_q  <= bit_timer_d;
            active_div_q <= active_div_d;
            baud_div_q   <= baud_div_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; clearing pointers and count discards its contents.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wdata_in[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: self-checking bench for uart_tx_mmio.
// Every clock the serial line is logged on the falling edge; expected line
// waveforms are built from frame arithmetic (start 0, 8 data bits LSB
// first, stop 1, each bit div clocks) and compared against the log.
module tb_uart_tx_mmio;

    localparam int DEPTH = 4;
    localparam logic [31:0] A_TX = 32'h0;
    localparam logic [31:0] A_ST = 32'h4;
    localparam logic [31:0] A_BD = 32'h8;
    localparam logic [31:0] A_RS = 32'hC;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        ce_in;
    logic        we_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata_out;
    logic        tx_out;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic        last_ok;
    logic        log_en = 1'b0;
    logic        line_q[$];
    frame_t      exp_frames[$];
    logic [7:0]  burst_q[$];

    uart_tx_mmio #(
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .ce_in    (ce_in),
        .we_in    (we_in),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .rdata_out(rdata_out),
        .tx_out   (tx_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (log_en) line_q.push_back(tx_out);
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        last_ok = (got === exp);
        if (!last_ok) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        ce_in = 1'b1; we_in = 1'b1; addr_in = addr; wdata_in = data;
        tick();
        ce_in = 1'b0; we_in = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        ce_in = 1'b1; we_in = 1'b0; addr_in = addr;
        #1;
        data = rdata_out;
        ce_in = 1'b0;
    endtask

    // TXDATA writes on consecutive edges, one per byte in burst_q.
    task automatic write_burst();
        foreach (burst_q[i]) begin
            ce_in = 1'b1; we_in = 1'b1; addr_in = A_TX; wdata_in = {24'h0, burst_q[i]};
            tick();
        end
        ce_in = 1'b0; we_in = 1'b0;
    endtask

    function automatic logic [31:0] status_word(input int cnt, input logic busy, input logic ovf);
        logic [31:0] w;
        w      = '0;
        w[8:4] = cnt[4:0];
        w[3]   = ovf;
        w[2]   = busy;
        w[1]   = (cnt == 0);
        w[0]   = (cnt == DEPTH);
        return w;
    endfunction

    task automatic wait_log(input int n);
        int guard;
        guard = 0;
        while (line_q.size() < n && guard < n + 50) begin
            tick();
            guard++;
        end
    endtask

    // Compare the line log: `start` idle-high samples, then exp_frames
    // back to back, then `tail` idle-high samples. Stops at first mismatch.
    task automatic check_log(input int start, input int tail, input string tag);
        logic exp_line[$];
        int   total;
        int   slot;
        logic b;
        for (int i = 0; i < start; i++) exp_line.push_back(1'b1);
        foreach (exp_frames[f]) begin
            for (int c = 0; c < 10 * exp_frames[f].div; c++) begin
                slot = c / exp_frames[f].div;
                if (slot == 0)      b = 1'b0;
                else if (slot == 9) b = 1'b1;
                else                b = exp_frames[f].data[slot - 1];
                exp_line.push_back(b);
            end
        end
        for (int i = 0; i < tail; i++) exp_line.push_back(1'b1);
        total = exp_line.size();
        wait_log(total);
        check({tag, "_len_ok"}, 32'(line_q.size() >= total), 32'd1);
        if (last_ok) begin
            for (int i = 0; i < total; i++) begin
                check($sformatf("%s_line[%0d]", tag, i), 32'(line_q[i]), 32'(exp_line[i]));
                if (!last_ok) break;
            end
        end
        log_en = 1'b0;
        line_q.delete();
        exp_frames.delete();
    endtask

    // Burst of n random bytes into an idle transmitter. Only the first pop
    // falls inside the burst window, so DEPTH+1 bytes are accepted at most.
    task automatic run_burst(input int n, input int div, input logic clr, input string tag);
        logic [31:0] st;
        logic [31:0] wd;
        int          acc;
        logic        ovf;
        bus_write(A_BD, 32'(div));
        log_en = 1'b1;
        burst_q.delete();
        for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom_range(0, 255)));
        write_burst();
        tick();
        acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
        ovf = (n > DEPTH + 1);
        bus_read(A_ST, st);
        check({tag, "_status"}, st, status_word(acc - 1, 1'b1, ovf));
        if (ovf) begin
            wd    = $urandom;
            wd[3] = clr;
            bus_write(A_ST, wd);
            bus_read(A_ST, st);
            check({tag, "_status_clr"}, st, status_word(acc - 1, 1'b1, ovf & ~clr));
        end
        for (int i = 0; i < acc; i++) exp_frames.push_back('{burst_q[i], div});
        check_log(2, 3, tag);
        bus_read(A_ST, st);
        check({tag, "_status_end"}, st, status_word(0, 1'b0, ovf & ~clr));
        if (ovf && !clr) begin
            bus_write(A_ST, 32'h8);
            bus_read(A_ST, st);
            check({tag, "_status_final"}, st, status_word(0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          peak;
        logic [7:0]  bx, by;

        reset_in = 1'b0; ce_in = 1'b0; we_in = 1'b0; addr_in = '0; wdata_in = '0;
        #1 reset_in = 1'b1;
        #2 check("rst_tx_during", 32'(tx_out), 32'd1);
        repeat (2) @(posedge clk_in);
        #3 reset_in = 1'b0;
        tick();

        // Reset state and register map.
        check("rst_tx", 32'(tx_out), 32'd1);
        bus_read(A_ST, rd); check("rst_status", rd, 32'h002);
        bus_read(A_BD, rd); check("rst_baud", rd, 32'd868);
        bus_read(A_TX, rd); check("txdata_read", rd, 32'h0);
        bus_read(A_RS, rd); check("rsvd_read", rd, 32'h0);
        addr_in = A_BD; ce_in = 1'b0; #1;
        check("ce_low_read", rdata_out, 32'h0);
        bus_write(A_RS, 32'hFFFF_FFFF);
        bus_read(A_RS, rd); check("rsvd_after_write", rd, 32'h0);
        bus_read(A_BD, rd); check("baud_after_rsvd_write", rd, 32'd868);

        // Single frame 0xA5 at 4 clocks per bit.
        bus_write(A_BD, 32'hFFFF_0004);
        bus_read(A_BD, rd); check("baud4", rd, 32'd4);
        log_en = 1'b1;
        bus_write(A_TX, 32'hA5);
        check("t2_no_bypass", 32'(tx_out), 32'd1);
        tick();
        check("t2_start_edge", 32'(tx_out), 32'd0);
        for (int c = 0; c < 40; c++) begin
            bus_read(A_ST, rd);
            check($sformatf("t2_busy[%0d]", c), 32'(rd[2]), 32'd1);
            tick();
        end
        bus_read(A_ST, rd); check("t2_status_idle", rd, 32'h002);
        exp_frames.push_back('{8'hA5, 4});
        check_log(2, 4, "t2");

        // Three bytes at 1 clock per bit, back to back.
        bus_write(A_BD, 32'd1);
        log_en = 1'b1;
        burst_q = '{8'h00, 8'hFF, 8'h55};
        write_burst();
        peak = 0;
        for (int c = 0; c < 30; c++) begin
            bus_read(A_ST, rd);
            if (int'(rd[8:4]) > peak) peak = int'(rd[8:4]);
            tick();
        end
        check("t3_peak_count", 32'(peak), 32'd2);
        exp_frames.push_back('{8'h00, 1});
        exp_frames.push_back('{8'hFF, 1});
        exp_frames.push_back('{8'h55, 1});
        check_log(2, 4, "t3");

        // Overflow with six writes at div 100; dropped byte never sent.
        run_burst(6, 100, 1'b1, "t4");

        // BAUD_DIV change mid-frame applies to the next frame only.
        bx = 8'($urandom_range(0, 255));
        by = 8'($urandom_range(0, 255));
        bus_write(A_BD, 32'd4);
        log_en = 1'b1;
        burst_q = '{bx, by};
        write_burst();
        repeat (3) tick();
        bus_write(A_BD, 32'd8);
        exp_frames.push_back('{bx, 4});
        exp_frames.push_back('{by, 8});
        check_log(2, 4, "t5");
        bus_read(A_BD, rd); check("t5_baud", rd, 32'd8);

        // Reset during the DATA phase of a frame.
        bus_write(A_BD, 32'd4);
        burst_q = '{8'h00, 8'hC3, 8'h3C};
        write_burst();
        repeat (12) tick();
        check("t6_tx_data_low", 32'(tx_out), 32'd0);
        bus_read(A_ST, rd); check("t6_status_mid", rd, status_word(2, 1'b1, 1'b0));
        #1 reset_in = 1'b1;
        #1 check("t6_tx_async", 32'(tx_out), 32'd1);
        bus_read(A_ST, rd); check("t6_status_in_reset", rd, 32'h002);
        repeat (2) @(posedge clk_in);
        #3 reset_in = 1'b0;
        tick();
        bus_read(A_ST, rd); check("t6_status_after", rd, 32'h002);
        bus_read(A_BD, rd); check("t6_baud_default", rd, 32'd868);
        log_en = 1'b1;
        check_log(100, 0, "t6_idle");
        bus_write(A_BD, 32'h0001_0000);
        bus_read(A_BD, rd); check("t6_baud_zero", rd, 32'd1);

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            run_burst(int'($urandom_range(1, 8)), int'($urandom_range(1, 5)),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
